// File: rtl/p_i_cache_ctrl_nway_if.sv
`default_nettype none
// ============================================================================
//  Module   : p_i_cache_ctrl_nway_if
//  Brief    : Control bundle between the N-way I-cache controller and its
//             datapath / CPU / memory neighbours.
//  Revision : 1.0  initial release
// ============================================================================
interface p_i_cache_ctrl_nway_if #(
    parameter int WAYS = 4,
    parameter int SETS = 8
);
    localparam int IDX_W = $clog2(SETS);

    logic               mem_read;
    logic               mem_resp;
    logic               pmem_read;
    logic               pmem_resp;
    logic               hit;
    logic [WAYS-1:0]    hit_vec;
    logic [WAYS-1:0]    valid_vec;
    logic [WAYS-2:0]    plru_in;
    logic               flush_req;
    logic [WAYS-1:0]    valid_load;
    logic               valid_datain;
    logic [WAYS-1:0]    tag_load;
    logic [WAYS-1:0]    data_we;
    logic               plru_load;
    logic [WAYS-2:0]    plru_datain;
    logic               load_stage_reg;
    logic [1:0]         addr_sel;
    logic [IDX_W-1:0]   flush_idx;
    logic               flush_busy;
    logic               flush_done;

    // Controller side
    modport master (
        input  mem_read, pmem_resp, hit, hit_vec, valid_vec, plru_in, flush_req,
        output mem_resp, pmem_read, valid_load, valid_datain, tag_load, data_we,
               plru_load, plru_datain, load_stage_reg, addr_sel, flush_idx,
               flush_busy, flush_done
    );

    // Datapath / environment side
    modport slave (
        output mem_read, pmem_resp, hit, hit_vec, valid_vec, plru_in, flush_req,
        input  mem_resp, pmem_read, valid_load, valid_datain, tag_load, data_we,
               plru_load, plru_datain, load_stage_reg, addr_sel, flush_idx,
               flush_busy, flush_done
    );
endinterface
`default_nettype wire

// File: rtl/p_i_cache_ctrl_nway.sv
`default_nettype none
// ============================================================================
//  Module   : p_i_cache_ctrl_nway
//  Brief    : Control FSM for a pipelined WAYS-way set-associative I-cache
//             with tree-PLRU replacement and a whole-cache flush sweep.
//  Revision : 1.0  initial release
// ============================================================================
module p_i_cache_ctrl_nway #(
    parameter int WAYS = 4,
    parameter int SETS = 8
) (
    input  wire logic               clk,
    input  wire logic               rst,
    p_i_cache_ctrl_nway_if.master   bus
);
    localparam int IDX_W = $clog2(SETS);
    localparam int NODES = WAYS - 1;

    localparam logic [1:0] SEL_CURR  = 2'd0;
    localparam logic [1:0] SEL_PREV  = 2'd1;
    localparam logic [1:0] SEL_FLUSH = 2'd2;

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_MISS  = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t             state_q,      state_d;
    logic               flush_pend_q, flush_pend_d;
    logic [IDX_W-1:0]   flush_idx_q,  flush_idx_d;

    logic [WAYS-1:0]    hit_oh;
    logic [WAYS-1:0]    inv_vec;
    logic [WAYS-1:0]    inv_oh;
    logic [WAYS-1:0]    excl_all;
    logic [WAYS-1:0]    victim_oh;
    logic [WAYS-2:0]    plru_upd;
    logic [WAYS-1:0]    excl [NODES];

    // Lowest set bit wins when several ways report a hit / are invalid.
    assign hit_oh  = bus.hit_vec & (~bus.hit_vec + WAYS'(1));
    assign inv_vec = ~bus.valid_vec;
    assign inv_oh  = inv_vec & (~inv_vec + WAYS'(1));

    // Each tree node covers a contiguous way range split into two halves.
    // Victim: every node rules out the half it does not point to; the one
    // surviving way is the PLRU victim. Update: nodes whose range holds the
    // hit way record which half was taken, the rest keep their old value.
    for (genvar k = 0; k < NODES; k++) begin : g_node
        localparam int DEPTH = $clog2(k + 2) - 1;
        localparam int POS   = k + 1 - (1 << DEPTH);
        localparam int SPAN  = WAYS >> DEPTH;
        localparam int LO    = POS * SPAN;
        localparam logic [WAYS-1:0] LOW_M  = WAYS'(((1 << (SPAN / 2)) - 1) << LO);
        localparam logic [WAYS-1:0] HIGH_M = WAYS'(((1 << (SPAN / 2)) - 1) << (LO + SPAN / 2));

        assign excl[k] = bus.plru_in[NODES-1-k] ? HIGH_M : LOW_M;
        assign plru_upd[NODES-1-k] = (|(hit_oh & (LOW_M | HIGH_M))) ?
                                     (|(hit_oh & HIGH_M)) : bus.plru_in[NODES-1-k];
    end

    // Combine node exclusions and prefer an invalid way over the PLRU choice.
    always_comb begin
        excl_all = '0;
        for (int i = 0; i < NODES; i++) begin
            excl_all = excl_all | excl[i];
        end
        victim_oh = (|inv_vec) ? inv_oh : ~excl_all;
    end

    // Next-state and output decode.
    always_comb begin
        state_d            = state_q;
        flush_pend_d       = flush_pend_q;
        flush_idx_d        = flush_idx_q;
        bus.mem_resp       = 1'b0;
        bus.pmem_read      = 1'b0;
        bus.valid_load     = '0;
        bus.valid_datain   = 1'b0;
        bus.tag_load       = '0;
        bus.data_we        = '0;
        bus.plru_load      = 1'b0;
        bus.plru_datain    = '0;
        bus.load_stage_reg = 1'b1;
        bus.addr_sel       = SEL_CURR;
        bus.flush_busy     = 1'b0;
        bus.flush_done     = 1'b0;

        unique case (state_q)
            S_RUN: begin
                if (bus.mem_read && bus.hit) begin
                    bus.mem_resp    = 1'b1;
                    bus.plru_load   = 1'b1;
                    bus.plru_datain = plru_upd;
                end else if (bus.mem_read) begin
                    bus.load_stage_reg = 1'b0;
                    bus.addr_sel       = SEL_PREV;
                    state_d            = S_MISS;
                end
                // A flush wins over a same-cycle miss; the stalled lookup replays.
                if (bus.flush_req) begin
                    state_d      = S_FLUSH;
                    flush_pend_d = 1'b0;
                end
            end
            S_MISS: begin
                bus.load_stage_reg = 1'b0;
                bus.addr_sel       = SEL_PREV;
                bus.pmem_read      = 1'b1;
                if (bus.flush_req) begin
                    flush_pend_d = 1'b1;
                end
                if (bus.pmem_resp) begin
                    bus.tag_load     = victim_oh;
                    bus.valid_load   = victim_oh;
                    bus.data_we      = victim_oh;
                    bus.valid_datain = 1'b1;
                    if (flush_pend_q || bus.flush_req) begin
                        state_d      = S_FLUSH;
                        flush_pend_d = 1'b0;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_FLUSH: begin
                bus.load_stage_reg = 1'b0;
                bus.addr_sel       = SEL_FLUSH;
                bus.flush_busy     = 1'b1;
                bus.valid_load     = '1;
                bus.plru_load      = 1'b1;
                if (flush_idx_q == IDX_W'(SETS - 1)) begin
                    bus.flush_done = 1'b1;
                    flush_idx_d    = '0;
                    state_d        = S_RUN;
                end else begin
                    flush_idx_d = flush_idx_q + IDX_W'(1);
                end
            end
            default: begin
                state_d = S_RUN;
            end
        endcase
    end

    assign bus.flush_idx = flush_idx_q;

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_RUN;
            flush_pend_q <= 1'b0;
            flush_idx_q  <= '0;
        end else begin
            state_q      <= state_d;
            flush_pend_q <= flush_pend_d;
            flush_idx_q  <= flush_idx_d;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_p_i_cache_ctrl_nway.sv
`default_nettype none
// ============================================================================
//  Module   : tb_p_i_cache_ctrl_nway
//  Brief    : Self-checking bench for p_i_cache_ctrl_nway (WAYS=4, SETS=8,
//             plus a WAYS=8 instance for the wide PLRU update case).
//  Revision : 1.0  initial release
// ============================================================================
module tb_p_i_cache_ctrl_nway;
    localparam int WAYS = 4;
    localparam int SETS = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    p_i_cache_ctrl_nway_if #(.WAYS(WAYS), .SETS(SETS)) bus ();
    p_i_cache_ctrl_nway #(.WAYS(WAYS), .SETS(SETS)) dut (.clk(clk), .rst(rst), .bus(bus));

    p_i_cache_ctrl_nway_if #(.WAYS(8), .SETS(SETS)) bus8 ();
    p_i_cache_ctrl_nway #(.WAYS(8), .SETS(SETS)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    function automatic int lowest_set(input logic [WAYS-1:0] v);
        for (int i = 0; i < WAYS; i++) if (v[i]) return i;
        return 0;
    endfunction

    // Walk root to leaf toward 'way', recording the side taken (1 = upper half).
    function automatic logic [WAYS-2:0] model_touch(input int way, input logic [WAYS-2:0] p);
        logic [WAYS-2:0] r;
        int node, lo, span, half;
        r = p; node = 0; lo = 0; span = WAYS;
        while (span > 1) begin
            half = span / 2;
            if (way >= lo + half) begin
                r[WAYS-2-node] = 1'b1; lo = lo + half; node = 2 * node + 2;
            end else begin
                r[WAYS-2-node] = 1'b0; node = 2 * node + 1;
            end
            span = half;
        end
        return r;
    endfunction

    function automatic int model_victim(input logic [WAYS-1:0] valid, input logic [WAYS-2:0] p);
        int node, lo, span, half;
        for (int i = 0; i < WAYS; i++) if (!valid[i]) return i;
        node = 0; lo = 0; span = WAYS;
        while (span > 1) begin
            half = span / 2;
            if (p[WAYS-2-node] == 1'b0) begin
                lo = lo + half; node = 2 * node + 2;
            end else begin
                node = 2 * node + 1;
            end
            span = half;
        end
        return lo;
    endfunction

    int m_mode = 0;     // 0 run, 1 waiting for fill, 2 sweeping
    bit m_pend = 1'b0;
    int m_idx  = 0;
    int n_mode, n_idx, v;
    bit n_pend;
    logic              e_resp, e_pread, e_vdin, e_pload, e_lsr, e_busy, e_done;
    logic [WAYS-1:0]   e_vload, e_tload, e_dwe;
    logic [WAYS-2:0]   e_pdin;
    logic [1:0]        e_sel;

    // Compare DUT against model mid-cycle, then advance the model.
    always @(negedge clk) begin
        if (rst) begin
            m_mode = 0; m_pend = 1'b0; m_idx = 0;
        end else begin
            e_resp = 0; e_pread = 0; e_vdin = 0; e_pload = 0; e_lsr = 1; e_busy = 0; e_done = 0;
            e_vload = '0; e_tload = '0; e_dwe = '0; e_pdin = '0; e_sel = 2'd0;
            n_mode = m_mode; n_pend = m_pend; n_idx = m_idx;
            if (m_mode == 0) begin
                if (bus.mem_read && bus.hit) begin
                    e_resp = 1; e_pload = 1;
                    e_pdin = model_touch(lowest_set(bus.hit_vec), bus.plru_in);
                end else if (bus.mem_read) begin
                    e_lsr = 0; e_sel = 2'd1; n_mode = 1;
                end
                if (bus.flush_req) begin n_mode = 2; n_pend = 1'b0; end
            end else if (m_mode == 1) begin
                e_lsr = 0; e_sel = 2'd1; e_pread = 1;
                if (bus.flush_req) n_pend = 1'b1;
                if (bus.pmem_resp) begin
                    v = model_victim(bus.valid_vec, bus.plru_in);
                    e_tload = '0; e_tload[v] = 1'b1;
                    e_vload = e_tload; e_dwe = e_tload; e_vdin = 1;
                    if (n_pend) begin n_mode = 2; n_pend = 1'b0; end
                    else n_mode = 0;
                end
            end else begin
                e_lsr = 0; e_sel = 2'd2; e_busy = 1; e_vload = '1; e_pload = 1;
                if (m_idx == SETS - 1) begin e_done = 1; n_mode = 0; n_idx = 0; end
                else n_idx = m_idx + 1;
            end
            chk("mem_resp",       bus.mem_resp,       e_resp);
            chk("pmem_read",      bus.pmem_read,      e_pread);
            chk("valid_load",     bus.valid_load,     e_vload);
            chk("valid_datain",   bus.valid_datain,   e_vdin);
            chk("tag_load",       bus.tag_load,       e_tload);
            chk("data_we",        bus.data_we,        e_dwe);
            chk("plru_load",      bus.plru_load,      e_pload);
            chk("plru_datain",    bus.plru_datain,    e_pdin);
            chk("load_stage_reg", bus.load_stage_reg, e_lsr);
            chk("addr_sel",       bus.addr_sel,       e_sel);
            chk("flush_idx",      bus.flush_idx,      m_idx);
            chk("flush_busy",     bus.flush_busy,     e_busy);
            chk("flush_done",     bus.flush_done,     e_done);
            m_mode = n_mode; m_pend = n_pend; m_idx = n_idx;
        end
    end

    // ---------------- stimulus ----------------
    task automatic nxt();  @(posedge clk); #1; endtask
    task automatic half(); @(negedge clk);     endtask

    task automatic idle();
        bus.mem_read = 0; bus.pmem_resp = 0; bus.hit = 0; bus.hit_vec = '0;
        bus.valid_vec = '0; bus.plru_in = '0; bus.flush_req = 0;
    endtask

    logic [2:0] pl_tab [4] = '{3'b000, 3'b110, 3'b100, 3'b011};
    int         wy_tab [4] = '{3, 0, 1, 2};
    logic [WAYS-1:0] onehot;

    initial begin
        idle();
        bus8.mem_read = 0; bus8.pmem_resp = 0; bus8.hit = 0; bus8.hit_vec = '0;
        bus8.valid_vec = '0; bus8.plru_in = '0; bus8.flush_req = 0;
        rst = 1; nxt(); nxt(); rst = 0;

        // Reset state
        half();
        chk("rst_load_stage_reg", bus.load_stage_reg, 1);
        chk("rst_flush_idx", bus.flush_idx, 0);
        chk("rst_addr_sel", bus.addr_sel, 0);
        nxt();

        // Pin the model's PLRU helpers
        chk("pin_victim_000", model_victim(4'hF, 3'b000), 3);
        chk("pin_victim_110", model_victim(4'hF, 3'b110), 0);
        chk("pin_victim_100", model_victim(4'hF, 3'b100), 1);
        chk("pin_victim_011", model_victim(4'hF, 3'b011), 2);
        chk("pin_victim_inv", model_victim(4'b1011, 3'b000), 2);
        chk("pin_touch_w0", model_touch(0, 3'b001), 3'b001);

        // Cold miss, fill on the third miss cycle, then replay hits
        bus.mem_read = 1; bus.hit = 0; bus.valid_vec = '0; bus.plru_in = '0;
        half(); chk("cold_stall", bus.load_stage_reg, 0); chk("cold_sel", bus.addr_sel, 1); nxt();
        half(); chk("cold_pmem1", bus.pmem_read, 1); nxt();
        half(); chk("cold_pmem2", bus.pmem_read, 1); nxt();
        bus.pmem_resp = 1;
        half();
        chk("cold_tag_load", bus.tag_load, 4'b0001);
        chk("cold_valid_load", bus.valid_load, 4'b0001);
        chk("cold_data_we", bus.data_we, 4'b0001);
        nxt();
        bus.pmem_resp = 0; bus.hit = 1; bus.hit_vec = 4'b0001; bus.plru_in = 3'b001; bus.valid_vec = 4'b0001;
        half(); chk("replay_resp", bus.mem_resp, 1); chk("replay_plru", bus.plru_datain, 3'b001); nxt();

        // PLRU victim with a full set
        for (int i = 0; i < 4; i++) begin
            bus.mem_read = 1; bus.hit = 0; bus.hit_vec = '0; bus.valid_vec = 4'hF; bus.plru_in = pl_tab[i];
            nxt();
            bus.pmem_resp = 1;
            onehot = '0; onehot[wy_tab[i]] = 1'b1;
            half(); chk("plru_victim", bus.tag_load, onehot); nxt();
            bus.pmem_resp = 0; bus.mem_read = 0;
            nxt();
        end

        // Eight-way PLRU update
        bus8.mem_read = 1; bus8.hit = 1; bus8.hit_vec = 8'b0010_0000; bus8.plru_in = 7'h00;
        half(); chk("w8_plru_load", bus8.plru_load, 1); chk("w8_plru_datain", bus8.plru_datain, 7'h42); nxt();
        bus8.mem_read = 0; bus8.hit = 0; bus8.hit_vec = '0;

        // Flush from RUN
        idle(); bus.flush_req = 1; nxt();
        bus.flush_req = 0; bus.mem_read = 1; bus.hit = 1; bus.hit_vec = 4'b0001;
        for (int i = 0; i < SETS; i++) begin
            half();
            chk("flush_idx_seq", bus.flush_idx, i);
            chk("flush_done_seq", bus.flush_done, (i == SETS - 1));
            chk("flush_no_resp", bus.mem_resp, 0);
            chk("flush_vload", bus.valid_load, 4'hF);
            nxt();
        end
        idle();
        half(); chk("post_flush_busy", bus.flush_busy, 0); nxt();

        // Flush requested during a miss
        bus.mem_read = 1; bus.hit = 0; bus.valid_vec = 4'hF; bus.plru_in = 3'b000; nxt();
        bus.flush_req = 1; half(); chk("mf_pmem", bus.pmem_read, 1); nxt();
        bus.flush_req = 0; bus.mem_read = 0; half(); chk("mf_pmem_hold", bus.pmem_read, 1); nxt();
        bus.pmem_resp = 1; half(); chk("mf_fill", bus.tag_load, 4'b1000); nxt();
        bus.pmem_resp = 0; bus.mem_read = 1;
        for (int i = 0; i < SETS; i++) begin
            half(); chk("mf_busy", bus.flush_busy, 1); chk("mf_no_pmem", bus.pmem_read, 0); nxt();
        end
        half(); chk("mf_replay_miss", bus.load_stage_reg, 0); chk("mf_replay_busy", bus.flush_busy, 0); nxt();
        bus.pmem_resp = 1; nxt();
        idle(); nxt();

        // Reset mid-flush
        bus.flush_req = 1; nxt();
        bus.flush_req = 0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) rst = 1;
            half(); chk("pre_rst_idx", bus.flush_idx, i); nxt();
        end
        rst = 0;
        half();
        chk("rst_flush_idx0", bus.flush_idx, 0);
        chk("rst_flush_busy", bus.flush_busy, 0);
        chk("rst_flush_lsr", bus.load_stage_reg, 1);
        nxt();

        // Randomised traffic against the model
        for (int c = 0; c < 600; c++) begin
            bus.mem_read  = ($urandom_range(0, 9) < 8);
            bus.hit       = ($urandom_range(0, 9) < 6);
            if (bus.hit) begin
                if ($urandom_range(0, 3) == 0) bus.hit_vec = 4'($urandom_range(1, 15));
                else begin bus.hit_vec = '0; bus.hit_vec[$urandom_range(0, 3)] = 1'b1; end
            end else bus.hit_vec = '0;
            bus.valid_vec = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom_range(0, 15));
            bus.plru_in   = 3'($urandom_range(0, 7));
            bus.pmem_resp = ($urandom_range(0, 3) == 0);
            bus.flush_req = ($urandom_range(0, 99) < 3);
            rst           = ($urandom_range(0, 99) == 0);
            nxt();
        end
        rst = 0; idle(); nxt(); nxt();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
`default_nettype wire
